// File: rtl/iir_sequencer_pkg.sv
// Shared encodings for the IIR sequencer and its operand mux: word sizes,
// select codes, FSM states and state-register indices.
package iir_sequencer_pkg;

    localparam int N_DEF = 25;
    localparam int F_DEF = 15;

    typedef enum logic [2:0] {
        CS_CERO = 3'b000, CS_A1, CS_A2, CS_B0, CS_B1, CS_B2
    } cs_e;

    typedef enum logic [1:0] {
        CC_CERO = 2'b00, CC_FK1, CC_FK2, CC_FK
    } cc_e;

    typedef enum logic [2:0] {
        CZ_CERO = 3'b000, CZ_UK, CZ_YK, CZ_ACUM1, CZ_ACUM2, CZ_ACUM3
    } cz_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_UPD
    } state_e;

    typedef struct packed {
        cs_e s;
        cc_e c;
        cz_e z;
    } sel_t;

    localparam int NREGS   = 8;
    localparam int R_UK    = 0;
    localparam int R_FK    = 1;
    localparam int R_FK1   = 2;
    localparam int R_FK2   = 3;
    localparam int R_YK    = 4;
    localparam int R_ACUM1 = 5;
    localparam int R_ACUM2 = 6;
    localparam int R_ACUM3 = 7;

    // Operand selection for each MAC step; non-MAC states select zero.
    function automatic sel_t sel_of(input state_e st);
        sel_t r;
        r = '{s: CS_CERO, c: CC_CERO, z: CZ_CERO};
        case (st)
            ST_S1:   r = '{s: CS_A1, c: CC_FK1, z: CZ_UK};
            ST_S2:   r = '{s: CS_A2, c: CC_FK2, z: CZ_ACUM1};
            ST_S3:   r = '{s: CS_B0, c: CC_FK,  z: CZ_CERO};
            ST_S4:   r = '{s: CS_B1, c: CC_FK1, z: CZ_ACUM3};
            ST_S5:   r = '{s: CS_B2, c: CC_FK2, z: CZ_ACUM1};
            default: r = '{s: CS_CERO, c: CC_CERO, z: CZ_CERO};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/iir_sequencer_if.sv
// Sample handshake, MAC select lines and registered operands between the
// sequencer (slave) and the surrounding datapath/ADC/DAC side (master).
interface iir_sequencer_if #(parameter int N = 25);
    logic         sample_tick;
    logic [N-1:0] uk_in;
    logic [N-1:0] mac_result;
    logic [2:0]   controlS;
    logic [1:0]   controlC;
    logic [2:0]   controlZ;
    logic [N-1:0] Uk, fk, fk1, fk2, yk, acum1, acum2, acum3;
    logic         busy;
    logic         y_valid;
    logic         overrun;

    modport master (
        output sample_tick, uk_in, mac_result,
        input  controlS, controlC, controlZ,
        input  Uk, fk, fk1, fk2, yk, acum1, acum2, acum3,
        input  busy, y_valid, overrun
    );

    modport slave (
        input  sample_tick, uk_in, mac_result,
        output controlS, controlC, controlZ,
        output Uk, fk, fk1, fk2, yk, acum1, acum2, acum3,
        output busy, y_valid, overrun
    );
endinterface

// File: rtl/iir_sequencer_state_regs.sv
// The eight operand registers fed back to the MAC mux. A write mask picks the
// destinations of wr_data; shift advances the delay line (fk -> fk1 -> fk2).
module iir_state_regs
    import iir_sequencer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREGS-1:0]           wr_en,
    input  logic [N-1:0]               wr_data,
    input  logic                       shift,
    output logic [NREGS-1:0][N-1:0]    q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en[i]) q[i] <= wr_data;
            end
            if (shift) begin
                q[R_FK2] <= q[R_FK1];
                q[R_FK1] <= q[R_FK];
            end
        end
    end

endmodule

// File: rtl/iir_sequencer.sv
// Second-order IIR control: walks one sample through five MAC steps, drives
// the operand selects and captures each MAC result into the state registers.
module iir_sequencer
    import iir_sequencer_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int F = F_DEF
) (
    input  logic              clk,
    input  logic              reset,
    iir_sequencer_if.slave    io
);

    if (F <= 0 || F >= N) begin : g_bad_f
        $error("iir_sequencer: F must lie in 1..N-1");
    end

    state_e                    state, state_nxt;
    sel_t                      sel_q;
    logic                      ovr_q;
    logic [NREGS-1:0]          wr_en;
    logic [N-1:0]              wr_data;
    logic                      shift;
    logic [NREGS-1:0][N-1:0]   q;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = '0;
        wr_data   = io.mac_result;
        shift     = 1'b0;
        case (state)
            ST_IDLE: if (io.sample_tick) begin
                state_nxt   = ST_S1;
                wr_en[R_UK] = 1'b1;
                wr_data     = io.uk_in;
            end
            ST_S1: begin
                state_nxt      = ST_S2;
                wr_en[R_ACUM1] = 1'b1;
            end
            // The new delay-line head equals the second partial sum.
            ST_S2: begin
                state_nxt      = ST_S3;
                wr_en[R_ACUM2] = 1'b1;
                wr_en[R_FK]    = 1'b1;
            end
            ST_S3: begin
                state_nxt      = ST_S4;
                wr_en[R_ACUM3] = 1'b1;
            end
            ST_S4: begin
                state_nxt      = ST_S5;
                wr_en[R_ACUM1] = 1'b1;
            end
            ST_S5: begin
                state_nxt   = ST_UPD;
                wr_en[R_YK] = 1'b1;
            end
            ST_UPD: begin
                state_nxt = ST_IDLE;
                shift     = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Selects come from the next state so they are glitch-free for a whole step.
    always_ff @(posedge clk) begin
        if (reset) sel_q <= '0;
        else       sel_q <= sel_of(state_nxt);
    end

    always_ff @(posedge clk) begin
        if (reset)                                   ovr_q <= 1'b0;
        else if (io.sample_tick && state != ST_IDLE) ovr_q <= 1'b1;
    end

    iir_state_regs #(.N(N)) u_regs (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .shift   (shift),
        .q       (q)
    );

    assign io.controlS = sel_q.s;
    assign io.controlC = sel_q.c;
    assign io.controlZ = sel_q.z;
    assign io.Uk       = q[R_UK];
    assign io.fk       = q[R_FK];
    assign io.fk1      = q[R_FK1];
    assign io.fk2      = q[R_FK2];
    assign io.yk       = q[R_YK];
    assign io.acum1    = q[R_ACUM1];
    assign io.acum2    = q[R_ACUM2];
    assign io.acum3    = q[R_ACUM3];
    assign io.busy     = (state != ST_IDLE);
    assign io.y_valid  = (state == ST_UPD);
    assign io.overrun  = ovr_q;

endmodule

// File: tb/tb_iir_sequencer.sv
// Bench for iir_sequencer: a modelled MAC closes the loop, and a direct-form-II
// reference filter predicts yk and the delay line for every sample.
module tb_iir_sequencer;

    localparam int N = 25;
    localparam int F = 15;
    typedef logic signed [N-1:0] word_t;

    localparam word_t A1 = word_t'(16384);   //  0.5
    localparam word_t A2 = word_t'(-8192);   // -0.25
    localparam word_t B0 = word_t'(8192);    //  0.25
    localparam word_t B1 = word_t'(16384);   //  0.5
    localparam word_t B2 = word_t'(8192);    //  0.25

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    iir_sequencer_if #(.N(N)) io ();
    iir_sequencer #(.N(N), .F(F)) dut (.clk(clk), .reset(reset), .io(io.slave));

    int checks = 0;
    int errors = 0;
    int yv_count = 0;
    word_t gf1, gf2;

    function automatic word_t mac(input word_t s, input word_t c, input word_t z);
        longint p;
        p = (longint'(s) * longint'(c)) >>> F;
        return word_t'(p + longint'(z));
    endfunction

    function automatic word_t coef(input logic [2:0] cs);
        case (cs)
            3'd1: return A1;
            3'd2: return A2;
            3'd3: return B0;
            3'd4: return B1;
            3'd5: return B2;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        word_t c_v, z_v;
        c_v = '0;
        z_v = '0;
        case (io.controlC)
            2'd1: c_v = io.fk1;
            2'd2: c_v = io.fk2;
            2'd3: c_v = io.fk;
            default: c_v = '0;
        endcase
        case (io.controlZ)
            3'd1: z_v = io.Uk;
            3'd2: z_v = io.yk;
            3'd3: z_v = io.acum1;
            3'd4: z_v = io.acum2;
            3'd5: z_v = io.acum3;
            default: z_v = '0;
        endcase
        io.mac_result = mac(coef(io.controlS), c_v, z_v);
    end

    // Reference filter: f = u + a1 f1 + a2 f2 ; y = b0 f + b1 f1 + b2 f2,
    // accumulated in the same order the datapath rounds its products.
    task automatic gold(input word_t u, output word_t y);
        word_t f;
        f = mac(A2, gf2, mac(A1, gf1, u));
        y = mac(B2, gf2, mac(B1, gf1, mac(B0, f, '0)));
        gf2 = gf1;
        gf1 = f;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic rst();
        reset = 1'b1;
        io.sample_tick = 1'b0;
        io.uk_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        gf1 = '0;
        gf2 = '0;
    endtask

    // One full sample starting in the current cycle; returns in the idle cycle
    // after UPD, so the next call lands exactly 7 cycles later.
    task automatic do_sample(input word_t u, input string tag);
        word_t ey;
        int lat;
        bit seen;
        gold(u, ey);
        io.sample_tick = 1'b1;
        io.uk_in = u;
        lat = 0;
        seen = 1'b0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(posedge clk);
            #1 io.sample_tick = 1'b0;
            @(negedge clk);
            if (k == 1) chkw({tag, "_uk"}, io.Uk, u);
            if (io.y_valid) begin
                seen = 1'b1;
                lat = k;
            end
        end
        if (seen) yv_count++;
        chk({tag, "_lat"}, 64'(lat), 64'd6);
        chkw({tag, "_yk"}, io.yk, ey);
        @(posedge clk);
        #1;
        @(negedge clk);
        chkw({tag, "_fk1"}, io.fk1, gf1);
        chkw({tag, "_fk2"}, io.fk2, gf2);
        chk({tag, "_idle"}, {62'd0, io.y_valid, io.busy}, 64'd0);
    endtask

    typedef struct {
        logic       tick;
        logic [2:0] s;
        logic [1:0] c;
        logic [2:0] z;
        logic       busy;
        logic       yv;
    } vec_t;

    vec_t tv[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        word_t u1, u2, ey;
        tv[0] = '{1'b1, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 3'd1, 2'd1, 3'd1, 1'b1, 1'b0};
        tv[2] = '{1'b0, 3'd2, 2'd2, 3'd3, 1'b1, 1'b0};
        tv[3] = '{1'b0, 3'd3, 2'd3, 3'd0, 1'b1, 1'b0};
        tv[4] = '{1'b0, 3'd4, 2'd1, 3'd5, 1'b1, 1'b0};
        tv[5] = '{1'b0, 3'd5, 2'd2, 3'd3, 1'b1, 1'b0};
        tv[6] = '{1'b0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b1};
        tv[7] = '{1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0};

        // Reset state held through 10 idle cycles.
        rst();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_ctl[%0d]", i),
                {52'd0, io.controlS, io.controlC, io.controlZ, io.busy, io.y_valid, io.overrun}, 64'd0);
            chkw($sformatf("idle_regs[%0d]", i),
                 io.Uk | io.fk | io.fk1 | io.fk2 | io.yk | io.acum1 | io.acum2 | io.acum3, '0);
            @(posedge clk);
            #1;
        end

        // Select trace for a single tick.
        for (int i = 0; i < 8; i++) begin
            io.sample_tick = tv[i].tick;
            io.uk_in = word_t'(32768);
            @(negedge clk);
            chk($sformatf("trace[%0d]", i),
                {54'd0, io.controlS, io.controlC, io.controlZ, io.busy, io.y_valid},
                {54'd0, tv[i].s, tv[i].c, tv[i].z, tv[i].busy, tv[i].yv});
            @(posedge clk);
            #1;
        end

        // Impulse response, 20 samples.
        rst();
        for (int i = 0; i < 20; i++)
            do_sample(i == 0 ? word_t'(32768) : word_t'(0), $sformatf("imp%0d", i));

        // Tick during busy: ignored, overrun sticky, result unaffected.
        rst();
        u1 = word_t'(20000);
        u2 = word_t'(-12345);
        gold(u1, ey);
        io.sample_tick = 1'b1;
        io.uk_in = u1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1 io.sample_tick = (k == 3);
            io.uk_in = (k == 3) ? u2 : u1;
            @(negedge clk);
            if (k == 3) chk("ovr_before", 64'(io.overrun), 64'd0);
            if (k >= 4) chk($sformatf("ovr_after[%0d]", k), 64'(io.overrun), 64'd1);
            if (k >= 4) chkw($sformatf("ovr_uk[%0d]", k), io.Uk, u1);
            if (k == 6) chkw("ovr_yk", io.yk, ey);
        end
        chk("ovr_no_restart", 64'(io.busy), 64'd0);

        // Reset asserted in S3 clears everything next cycle.
        rst();
        do_sample(word_t'(30000), "pre");
        io.sample_tick = 1'b1;
        io.uk_in = word_t'(7777);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1 io.sample_tick = 1'b0;
            if (k == 3) reset = 1'b1;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_s3_ctl", {53'd0, io.controlS, io.controlC, io.controlZ, io.busy, io.y_valid}, 64'd0);
        chkw("rst_s3_regs", io.Uk | io.fk | io.fk1 | io.fk2 | io.yk | io.acum1 | io.acum2 | io.acum3, '0);
        gf1 = '0;
        gf2 = '0;
        do_sample(word_t'(-25000), "post");

        // Tick coincident with reset is dropped.
        reset = 1'b1;
        io.sample_tick = 1'b1;
        io.uk_in = word_t'(1234);
        @(posedge clk);
        #1 reset = 1'b0;
        io.sample_tick = 1'b0;
        @(negedge clk);
        chk("rst_tick_busy", 64'(io.busy), 64'd0);
        chkw("rst_tick_uk", io.Uk, '0);
        gf1 = '0;
        gf2 = '0;

        // 50 random samples back to back.
        yv_count = 0;
        for (int i = 0; i < 50; i++) begin
            int r;
            r = int'($urandom_range(131072)) - 65536;
            do_sample(word_t'(r), $sformatf("rnd%0d", i));
        end
        chk("b2b_overrun", 64'(io.overrun), 64'd0);
        chk("b2b_yvalid_count", 64'(yv_count), 64'd50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_sequencer.md
# iir_sequencer

Control and state-holding end of the second-order IIR datapath. It sequences one filter sample through five multiply-accumulate steps by driving the operand-select lines of the coefficient/operand mux. It captures each MAC result into the delay-line and accumulator registers, and those registers feed back to the mux inputs. It also owns the sample handshake to the ADC side and the DAC side.

## Interface
Parameters:
- N, default `N (25): datapath word width, two's complement fixed point.
- F, default `F (15): fractional bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sample_tick  in  1  one-cycle pulse: new input sample on uk_in.
- uk_in  in  N  input sample.
- mac_result  in  N  combinational result muxS*muxC + muxZ, already rescaled to N bits.
- controlS  out  3  coefficient select: 000 cero, 001 a1, 010 a2, 011 b0, 100 b1, 101 b2.
- controlC  out  2  delay select: 00 cero, 01 fk1, 10 fk2, 11 fk.
- controlZ  out  3  addend select: 000 cero, 001 Uk, 010 yk, 011 acum1, 100 acum2, 101 acum3.
- Uk, fk, fk1, fk2, yk, acum1, acum2, acum3  out  N each  registered operands back to the mux.
- busy  out  1  high while a sample is in process.
- y_valid  out  1  one-cycle pulse when yk is updated.
- overrun  out  1  sticky flag: a sample_tick arrived while busy. Cleared only by reset.

## Operation
- FSM states: IDLE, S1, S2, S3, S4, S5, UPD.
- IDLE:
  - Control outputs are all zero.
  - On sample_tick, Uk ← uk_in, then go to S1.
- Each Sx state drives the fixed selects below and latches mac_result into the listed destination at the end of the cycle:
  - S1: S=001, C=01, Z=001, acum1 ← a1·fk1 + Uk.
  - S2: S=010, C=10, Z=011, acum2 ← a2·fk2 + acum1, and fk ← same value.
  - S3: S=011, C=11, Z=000, acum3 ← b0·fk.
  - S4: S=100, C=01, Z=101, acum1 ← b1·fk1 + acum3.
  - S5: S=101, C=10, Z=011, yk ← b2·fk2 + acum1.
- UPD:
  - fk2 ← fk1 and fk1 ← fk, both in the same cycle.
  - Control outputs return to zero.
  - y_valid = 1 for this cycle.
  - Next state is IDLE.
- Coefficient signs are folded into the mux constants, so the sequencer only ever adds.
- Arithmetic width: mac_result is taken verbatim. Saturation and rounding belong to the MAC.
- The selects are registered outputs, decoded from the next-state value, so they are stable for the whole of each Sx cycle.

## Timing
- Reset values:
  - All data registers are 0.
  - Selects are 000 / 00 / 000.
  - busy = 0, y_valid = 0, overrun = 0.
  - State is IDLE.
- Latency: tick in cycle t; S1 in t+1 through S5 in t+5; UPD in t+6. yk is valid and y_valid is high in cycle t+6.
- busy is high from t+1 through t+6 inclusive.
- Throughput: one sample per 7 cycles.
- A sample_tick in UPD or any Sx state is ignored, Uk is unchanged, and overrun is set.
- A sample_tick in the same cycle as reset is ignored. Reset wins.
- Reset mid-sequence (any state) returns to IDLE on the next edge. The delay line is cleared, with no partial update of fk1/fk2.
- Delay registers are written only in S2 (fk) and UPD (fk1, fk2).

## Structure
- Shared header constantes.h holds:
  - `N and `F;
  - the select encodings (CS_*, CC_*, CZ_*);
  - the FSM state codes.
- The mux module and this block both include these definitions, so the encodings cannot diverge.
- One sub-module, iir_state_regs: the eight N-bit registers, with write enables and a destination index supplied by the FSM. The FSM and decode logic stay in iir_sequencer.

## Test plan
- Reset, then idle 10 cycles:
  - all outputs stay at their reset values;
  - busy = 0, and selects = 0 in every cycle.
- Select trace: one tick.
  - Required select sequence for S1..S5: 001/01/001, 010/10/011, 011/11/000, 100/01/101, 101/10/011.
  - y_valid is high exactly in cycle t+6.
- Model the MAC in the bench; with N=25, F=15:
  - Impulse: uk_in = 0x008000 (1.0) followed by zero samples.
  - The yk sequence matches a golden fixed-point model bit-exactly for 20 samples.
  - Check fk1 and fk2 shift correctly after each UPD.
- Tick at t+3 during busy:
  - overrun = 1 from t+4 onward;
  - Uk is unchanged;
  - the result equals the single-tick result.
- Reset asserted during S3:
  - next cycle, state is IDLE, all registers are 0, and busy = 0;
  - a subsequent tick processes normally from zeroed delays.
- Back-to-back ticks every 7 cycles for 50 samples:
  - overrun never sets;
  - one y_valid per sample.
